// File: rtl/ustawienie_pkg.sv
// Shared types and the index-encoding rule for the bit-set unit.
// Build option: define USTAWIENIE_SIGN_MAG_EN for a sign-magnitude index (default two's complement).
package ustawienie_pkg;

  localparam int unsigned BITS_DEFAULT = 32;

  typedef logic [BITS_DEFAULT-1:0] word_t;

`ifdef USTAWIENIE_SIGN_MAG_EN
  localparam bit SIGN_MAG = 1'b1;
`else
  localparam bit SIGN_MAG = 1'b0;
`endif

  // Sign acceptance only; -0 is legal in sign-magnitude, every set sign bit fails otherwise.
  function automatic logic sign_ok(input logic neg, input logic mag_zero);
    return !neg || (SIGN_MAG && mag_zero);
  endfunction

  function automatic logic idx_valid(input word_t b);
    logic [BITS_DEFAULT-2:0] mag;
    mag = b[BITS_DEFAULT-2:0];
    return sign_ok(b[BITS_DEFAULT-1], mag == '0) &&
           (mag < (BITS_DEFAULT-1)'(BITS_DEFAULT));
  endfunction

endpackage

// File: rtl/ustawienie_bitu_if.sv
// Operand/result bundle of the bit-set unit.
interface ustawienie_bitu_if #(
  parameter int unsigned BITS = 32
);

  logic [BITS-1:0] i_arg_A;
  logic [BITS-1:0] i_arg_B;
  logic [BITS-1:0] o_result;
  logic            o_error;

  modport master (
    output i_arg_A,
    output i_arg_B,
    input  o_result,
    input  o_error
  );

  modport slave (
    input  i_arg_A,
    input  i_arg_B,
    output o_result,
    output o_error
  );

endinterface

// File: rtl/ustawienie_dekoder.sv
// Combinational index decoder: one-hot mask for a valid index, error flag otherwise.
module ustawienie_dekoder
  import ustawienie_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEFAULT
) (
  input  logic [BITS-1:0] i_arg_B,
  output logic [BITS-1:0] o_mask,
  output logic            o_err
);

  // Wide enough to hold both the full magnitude and the value BITS, so no high bit is lost.
  localparam int unsigned W = (BITS > 32) ? BITS + 1 : 33;

  logic [W-1:0] mag;
  logic         neg;
  logic         valid;

  always_comb begin
    neg    = i_arg_B[BITS-1];
    mag    = W'(i_arg_B[BITS-2:0]);
    valid  = sign_ok(neg, mag == '0) && (mag < W'(BITS));
    o_err  = !valid;
    o_mask = '0;
    for (int unsigned i = 0; i < BITS; i++) begin
      o_mask[i] = valid && (mag == W'(i));
    end
  end

endmodule

// File: rtl/ustawienie_bitu.sv
// Registered bit-set unit: result = A with bit B set, or zero with error for a bad index.
// Encoding of B selected by USTAWIENIE_SIGN_MAG_EN (see ustawienie_pkg).
module ustawienie_bitu
  import ustawienie_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  ustawienie_bitu_if.slave  bus
);

  logic [BITS-1:0] mask;
  logic            err;
  logic [BITS-1:0] result_d, result_q;
  logic            error_d, error_q;

  ustawienie_dekoder #(
    .BITS (BITS)
  ) u_dekoder (
    .i_arg_B (bus.i_arg_B),
    .o_mask  (mask),
    .o_err   (err)
  );

  always_comb begin
    result_d = err ? '0 : (bus.i_arg_A | mask);
    error_d  = err;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign bus.o_result = result_q;
  assign bus.o_error  = error_q;

endmodule

// File: tb/tb_ustawienie_bitu.sv
// Self-checking bench for ustawienie_bitu (BITS=32) against an integer-arithmetic model.
module tb_ustawienie_bitu;

`ifdef USTAWIENIE_SIGN_MAG_EN
  localparam bit SM = 1'b1;
`else
  localparam bit SM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  ustawienie_bitu_if #(.BITS(32)) bus ();

  ustawienie_bitu #(
    .BITS (32)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Interpret B as a signed integer and set bit idx arithmetically.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint idx;
    longint m;
    if (SM) begin
      m   = longint'(b[30:0]);
      idx = b[31] ? -m : m;
    end else begin
      idx = longint'($signed(b));
    end
    if (idx < 0 || idx >= 32) begin
      r = 32'h0;
      e = 1'b1;
    end else begin
      r = a[idx[4:0]] ? a : 32'(longint'(a) + (longint'(1) << idx));
      e = 1'b0;
    end
  endfunction

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    bus.i_arg_A = a;
    bus.i_arg_B = b;
    @(posedge clk);
    #1;
    model(a, b, r, e);
    check({tag, ".res"}, bus.o_result, r);
    check({tag, ".err"}, 32'(bus.o_error), 32'(e));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;

    // Reset holds outputs at zero regardless of inputs.
    rst = 1'b1;
    bus.i_arg_A = 32'hFFFF_FFFF;
    bus.i_arg_B = 32'd3;
    @(posedge clk);
    #1;
    check("rst.res", bus.o_result, 32'h0);
    check("rst.err", 32'(bus.o_error), 32'h0);
    rst = 1'b0;
    op("post_rst", 32'hFFFF_FFFF, 32'd3);
    check("post_rst.lit", bus.o_result, 32'hFFFF_FFFF);

    op("v0", 32'h0, 32'd0);
    check("v0.lit", bus.o_result, 32'h1);
    op("v5", 32'h0, 32'd5);
    check("v5.lit", bus.o_result, 32'h20);
    op("v31", 32'h0, 32'd31);
    check("v31.lit", bus.o_result, 32'h8000_0000);
    op("ones", 32'hFFFF_FFFF, 32'($urandom_range(31, 1)));

    op("neg1", 32'h1234_5678, 32'hFFFF_FFFF);
    check("neg1.lit", 32'(bus.o_error), 32'h1);
    op("neg5", 32'h1234_5678, 32'h8000_0005);
    check("neg5.lit", 32'(bus.o_error), 32'h1);
    op("big32", 32'hA5A5_A5A5, 32'd32);
    op("bigmax", 32'hA5A5_A5A5, 32'h7FFF_FFFF);
    op("bighi", 32'hA5A5_A5A5, 32'h0100_0000);
    check("bighi.lit", 32'(bus.o_error), 32'h1);
    op("mzero", 32'h0000_0100, 32'h8000_0000);
    check("mzero.lit", bus.o_result, SM ? 32'h0000_0101 : 32'h0);

    // Reset mid-stream discards the sampled operation.
    bus.i_arg_A = 32'h0F0F_0F0F;
    bus.i_arg_B = 32'hFFFF_FFFF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2.res", bus.o_result, 32'h0);
    check("rst2.err", 32'(bus.o_error), 32'h0);
    rst = 1'b0;

    // Back-to-back random mix of valid and invalid indices.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      case ($urandom_range(3, 0))
        0: b = 32'($urandom_range(40, 0));
        1: b = $urandom;
        2: b = 32'h8000_0000 | 32'($urandom_range(40, 0));
        default: b = 32'(1) << $urandom_range(31, 0);
      endcase
      op("rnd", a, b);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
